// File: rtl/mc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_pkg: state encodings and control-field codes for the FSM.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RTYPE_WB  = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  localparam logic [1:0] c_ALU_ADD   = 2'b00;
  localparam logic [1:0] c_ALU_SUB   = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT = 2'b10;

  localparam logic [1:0] c_SRCB_REG    = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
  localparam logic [1:0] c_SRCB_IMM    = 2'b10;
  localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] c_PC_ALU    = 2'b00;
  localparam logic [1:0] c_PC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PC_JUMP   = 2'b10;

  // States that stall on memory and are covered by the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_wait_timer: 8-bit memory wait counter with clear/enable/expire.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 8'd1;
  end

  // Expires on the stalled cycle whose increment would reach TIMEOUT.
  assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_control: Moore control FSM for a multicycle MIPS core. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t     r_state, w_next;
  logic [5:0] r_opcode;
  logic       r_cause_tmo;
  logic       w_tmr_en, w_expire, w_clear;

  assign w_tmr_en = is_wait_state(r_state) && !mem_ready;
  // Any state change restarts the count, so each wait state starts at zero.
  assign w_clear  = (w_next != r_state);

  mc_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_opcode    <= '0;
      r_cause_tmo <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
      if (w_expire)                 r_cause_tmo <= 1'b1;
      else if (r_state == S_DECODE) r_cause_tmo <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE; else if (w_expire) w_next = S_TRAP;
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE:       w_next = S_EXECUTE;
          c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_J:           w_next = S_JUMP;
          c_OP_ADDI:        w_next = S_ADDI_EX;
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  w_next = (r_opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB; else if (w_expire) w_next = S_TRAP;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;  else if (w_expire) w_next = S_TRAP;
      S_EXECUTE:   w_next = S_RTYPE_WB;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = c_SRCB_REG;
    alu_op        = c_ALU_ADD;
    pc_source     = c_PC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = c_SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = c_SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = c_ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = c_ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = c_PC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = c_PC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal_op  = !r_cause_tmo;
        mem_timeout = r_cause_tmo;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multicycle_control: directed and randomized checks of the FSM. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 3;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [18:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  assign obs = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal_op, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for a state, straight from the state output table.
  function automatic logic [18:0] ctl(input int s, input logic rdy, input logic tmo);
    logic pcw = 0, pcc = 0, irw = 0, mr = 0, mw = 0, iod = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    logic dn = 0, ill = 0, to = 0;
    case (s)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; iod = 1; dn = rdy; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; dn = 1; end
      9:  begin pcw = 1; psrc = 2'b10; dn = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      12: begin ill = !tmo; to = tmo; end
      default: ;
    endcase
    return {pcw, pcc, irw, mr, mw, iod, rd, m2r, rw, asa, asb, aop, psrc, dn, ill, to};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'h3F;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (state !== 4'd0 || obs !== ctl(0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset: state=%0d ctl=%h, want state=0 ctl=%h", state, obs, ctl(0, 1'b0, 1'b0));
    end
    rst = 1'b0; mem_ready = 1'b1; #1;
    n_tests++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL fetch_gate: ir_write=%b pc_write=%b state=%0d, want 1 1 0", ir_write, pc_write, state);
    end
  endtask

  task automatic test_lw();
    int exp[6] = '{0, 1, 2, 3, 4, 0};
    int dn = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      opcode = 6'b100011; mem_ready = 1'b1; #1;
      n_tests++;
      if (state !== 4'(exp[i]) || reg_write !== (exp[i] == 4) || mem_to_reg !== (exp[i] == 4)) begin
        n_fail++;
        $display("FAIL lw[%0d]: state=%0d rw=%b m2r=%b, want state=%0d", i, state, reg_write, mem_to_reg, exp[i]);
      end
      if (instr_done) dn++;
      tick();
    end
    n_tests++;
    if (dn != 1) begin n_fail++; $display("FAIL lw_done: pulses=%0d, want 1", dn); end
  endtask

  task automatic test_rtype();
    int exp[5] = '{0, 1, 6, 7, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode = 6'b000000; mem_ready = 1'b1; #1;
      n_tests++;
      if (state !== 4'(exp[i]) ||
          (exp[i] == 6 && alu_op !== 2'b10) ||
          (exp[i] == 7 && (reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0))) begin
        n_fail++;
        $display("FAIL rtype[%0d]: state=%0d alu_op=%b reg_dst=%b rw=%b, want state=%0d", i, state, alu_op, reg_dst, reg_write, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    int exp[4] = '{0, 1, 12, 0};
    int ill = 0, bad_we = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b111111; mem_ready = (i == 0); #1;
      n_tests++;
      if (state !== 4'(exp[i]) || mem_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal[%0d]: state=%0d tmo=%b, want state=%0d tmo=0", i, state, mem_timeout, exp[i]);
      end
      if (illegal_op) ill++;
      if (pc_write_cond || mem_write || reg_write || (exp[i] != 0 && (pc_write || ir_write))) bad_we++;
      tick();
    end
    n_tests++;
    if (ill != 1 || bad_we != 0) begin
      n_fail++;
      $display("FAIL illegal_pulse: cycles=%0d write_en=%0d, want 1 0", ill, bad_we);
    end
  endtask

  task automatic test_sw_timeout();
    int exp[8] = '{0, 1, 2, 5, 5, 5, 12, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = 6'b101011; mem_ready = (i == 0); #1;
      n_tests++;
      if (state !== 4'(exp[i]) ||
          (exp[i] == 5 && (mem_write !== 1'b1 || instr_done !== 1'b0)) ||
          (exp[i] == 12 && (mem_timeout !== 1'b1 || illegal_op !== 1'b0 || mem_write !== 1'b0))) begin
        n_fail++;
        $display("FAIL sw_tmo[%0d]: state=%0d mw=%b done=%b tmo=%b ill=%b, want state=%0d", i, state, mem_write, instr_done, mem_timeout, illegal_op, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_ready_boundary();
    int   exp[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
    logic rdy[10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    int dn = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      opcode = 6'b100011; mem_ready = rdy[i]; #1;
      n_tests++;
      if (state !== 4'(exp[i]) || mem_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary[%0d]: state=%0d tmo=%b, want state=%0d tmo=0", i, state, mem_timeout, exp[i]);
      end
      if (instr_done) dn++;
      tick();
    end
    n_tests++;
    if (dn != 1) begin n_fail++; $display("FAIL boundary_done: pulses=%0d, want 1", dn); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      opcode = 6'b000000; mem_ready = 1'b1; tick();
    end
    n_tests++;
    if (state !== 4'd6) begin n_fail++; $display("FAIL mid_pre: state=%0d, want 6", state); end
    rst = 1'b1; #1;
    n_tests++;
    if (state !== 4'd0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: state=%0d rw=%b, want 0 0", state, reg_write);
    end
    tick();
    rst = 1'b0; mem_ready = 1'b0; #1;
    n_tests++;
    if (state !== 4'd0 || reg_write || ir_write || pc_write || mem_write || pc_write_cond) begin
      n_fail++;
      $display("FAIL mid_release: state=%0d ctl=%h, want state=0 no write enables", state, obs);
    end
    tick(); #1;
    n_tests++;
    if (state !== 4'd0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: state=%0d rw=%b, want 0 0", state, reg_write);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[2] = '{6'b000100, 6'b000010};
    int         tgt[2] = '{8, 9};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      opcode = ops[k]; mem_ready = 1'b1;
      tick(); tick(); #1;
      n_tests++;
      if (state !== 4'(tgt[k]) || obs !== ctl(tgt[k], 1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL branch_jump[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h", k, state, obs, tgt[k], ctl(tgt[k], 1'b1, 1'b0));
      end
      n_tests++;
      if ((k == 0 && (pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01)) ||
          (k == 1 && (pc_write !== 1'b1 || pc_source !== 2'b10))) begin
        n_fail++;
        $display("FAIL bj_fields[%0d]: pcw=%b pcc=%b psrc=%b aop=%b", k, pc_write, pc_write_cond, pc_source, alu_op);
      end
    end
  endtask

  // Instruction-level model: each opcode maps to its list of states, and the
  // three memory states stretch by stall cycles until ready or timeout.
  task automatic test_random();
    logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
    logic [5:0] op;
    int   seq[$];
    int   k, s, waits;
    logic rdy, tmo;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      case (op)
        6'h00:   seq = '{1, 6, 7};
        6'h23:   seq = '{1, 2, 3, 4};
        6'h2B:   seq = '{1, 2, 5};
        6'h04:   seq = '{1, 8};
        6'h02:   seq = '{1, 9};
        6'h08:   seq = '{1, 10, 11};
        default: seq = '{1, 12};
      endcase
      seq.push_front(0);
      k = 0; waits = 0; tmo = 1'b0;
      while (k < seq.size()) begin
        s = seq[k];
        rdy = ($urandom_range(0, 99) < 55);
        mem_ready = rdy;
        opcode = (s == 1) ? op : 6'($urandom);
        #1;
        n_tests++;
        if (state !== 4'(s) || obs !== ctl(s, rdy, tmo)) begin
          n_fail++;
          $display("FAIL random op=%h step=%0d: state=%0d ctl=%h, want state=%0d ctl=%h", op, k, state, obs, s, ctl(s, rdy, tmo));
        end
        tick();
        if ((s == 0 || s == 3 || s == 5) && !rdy) begin
          waits++;
          if (waits == MEM_TIMEOUT) begin
            seq = '{12}; k = 0; waits = 0; tmo = 1'b1;
          end
        end else begin
          k++; waits = 0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0;
    test_reset();
    test_lw();
    test_rtype();
    test_illegal();
    test_sw_timeout();
    test_ready_boundary();
    test_reset_mid();
    test_branch_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
